eth_rx_deframer: RTL and testbench

//  Receive-side counterpart of the Ethernet framer. It acts as an AXI4-Lite master on the

---
 rtl/eth_rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_eth_rx_deframer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_deframer.sv
// Polls the Ethernet Lite MAC RX ping buffer over AXI4-Lite, streams the payload of
// frames carrying the expected EtherType, and releases every frame back to the MAC.
module eth_rx_deframer #(
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          MAX_WORDS     = 64,
  parameter int          POLL_INTERVAL = 1000
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic [12:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [12:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam logic [12:0] STATUS_ADDR = 13'h17FC;
  localparam logic [12:0] HDR_ADDR    = 13'h100C;
  localparam logic [12:0] PAY_BASE    = 13'h1010;

  typedef enum logic [3:0] {
    IDLE, POLL_AR, POLL_R, HDR_AR, HDR_R, PAY_AR, PAY_R, PAY_OUT, REL_AW, REL_B
  } state_t;

  state_t state, state_next;

  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          drop;
  logic          aw_done;
  logic          w_done;

  logic [15:0] ethertype_field;
  logic [15:0] n_field;
  logic        hdr_bad;
  logic        poll_done;
  logic        is_last;
  logic        aw_ok;
  logic        w_ok;
  logic [12:0] pay_addr;
  logic        unused_resp;

  // Header word 3 holds the EtherType and word count in network byte order.
  assign ethertype_field = {m_axi_rdata[7:0], m_axi_rdata[15:8]};
  assign n_field         = {m_axi_rdata[23:16], m_axi_rdata[31:24]};
  assign hdr_bad         = (ethertype_field != ETHERTYPE) || (n_field == 16'd0);
  assign poll_done       = (poll_cnt == PW'(POLL_INTERVAL - 1));
  assign is_last         = (idx == cnt - CW'(1));
  assign aw_ok           = aw_done | m_axi_awready;
  assign w_ok            = w_done | m_axi_wready;
  assign pay_addr        = PAY_BASE + (13'(idx) << 2);
  assign m_axi_wdata     = 32'h0000_0000;
  assign m_axi_wstrb     = 4'hF;
  assign unused_resp     = ^{m_axi_rresp, m_axi_bresp};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      poll_cnt       <= '0;
      idx            <= '0;
      cnt            <= '0;
      drop           <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      m_axis_tdata   <= '0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: poll_cnt <= poll_done ? '0 : poll_cnt + PW'(1);
        HDR_R: begin
          if (m_axi_rvalid) begin
            if (hdr_bad) begin
              drop <= 1'b1;
            end else begin
              cnt <= (n_field > 16'(MAX_WORDS)) ? CW'(MAX_WORDS) : n_field[CW-1:0];
              idx <= '0;
            end
          end
        end
        PAY_R: if (m_axi_rvalid) m_axis_tdata <= m_axi_rdata;
        PAY_OUT: if (m_axis_tready) idx <= idx + CW'(1);
        REL_AW: begin
          if (m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wready) w_done <= 1'b1;
          if (aw_ok && w_ok) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        REL_B: begin
          if (m_axi_bvalid) begin
            if (drop) frames_dropped <= frames_dropped + 16'd1;
            else      frames_ok      <= frames_ok + 16'd1;
            drop <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    m_axi_araddr  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: if (poll_done) state_next = POLL_AR;
      POLL_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = STATUS_ADDR;
        if (m_axi_arready) state_next = POLL_R;
      end
      POLL_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = m_axi_rdata[0] ? HDR_AR : IDLE;
      end
      HDR_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = HDR_ADDR;
        if (m_axi_arready) state_next = HDR_R;
      end
      HDR_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = hdr_bad ? REL_AW : PAY_AR;
      end
      PAY_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = pay_addr;
        if (m_axi_arready) state_next = PAY_R;
      end
      PAY_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = PAY_OUT;
      end
      PAY_OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = is_last;
        if (m_axis_tready) state_next = is_last ? REL_AW : PAY_AR;
      end
      REL_AW: begin
        m_axi_awaddr  = STATUS_ADDR;
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if (aw_ok && w_ok) state_next = REL_B;
      end
      REL_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Self-checking bench: a randomized MAC/AXI-Lite slave and stream sink drive
// eth_rx_deframer, checked against a frame-level model of what should be streamed.
module tb_eth_rx_deframer;

  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int MAXW = 64;
  localparam int POLL = 8;

  logic        aclk;
  logic        aresetn;
  logic [12:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [12:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  eth_rx_deframer #(.ETHERTYPE(ETYPE), .MAX_WORDS(MAXW), .POLL_INTERVAL(POLL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MAC model: RX buffer words and the frame-ready flag of the status register.
  logic [31:0] mem [0:511];
  bit          frame_ready;
  int n_status_reads = 0, n_buf_reads = 0, n_writes = 0, n_bresp = 0;

  // Reference model state.
  logic [32:0] exp_q[$];
  int  exp_ok = 0, exp_drop = 0;
  bit  cur_accept;
  int  cur_reads;
  int  b_base, r_base, w_base;

  // Stream sink state shared with the directed sequence.
  bit tvalid_seen;
  int words_seen;
  int stall_at, stall_len;
  bit stall_armed, stall_done;

  function automatic logic [31:0] macRead(input logic [12:0] addr);
    if (addr == 13'h17FC) return {31'b0, frame_ready};
    if (addr >= 13'h1000 && addr < 13'h17FC) return mem[9'((addr - 13'h1000) >> 2)];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin : rd_slave
    bit ar_fire, r_pend, r_fire;
    logic [12:0] r_addr;
    int r_dly;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    ar_fire = 0; r_pend = 0; r_fire = 0; r_addr = '0; r_dly = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        ar_fire = 0; r_pend = 0; r_fire = 0;
      end else begin
        if (ar_fire) begin
          r_pend = 1;
          r_dly = $urandom_range(0, 3);
          if (r_addr == 13'h17FC) n_status_reads++;
          else n_buf_reads++;
        end
        if (r_fire) m_axi_rvalid = 1'b0;
        m_axi_arready = m_axi_arvalid && !r_pend && !m_axi_rvalid && ($urandom_range(0, 2) == 0);
        ar_fire = m_axi_arready && m_axi_arvalid;
        if (ar_fire) r_addr = m_axi_araddr;
        if (r_pend) begin
          if (r_dly == 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata = macRead(r_addr);
            m_axi_rresp = 2'($urandom_range(0, 3));
            r_pend = 0;
          end else begin
            r_dly--;
          end
        end
        r_fire = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  initial begin : wr_slave
    bit aw_fire, w_fire, b_fire, aw_got, w_got, b_pend;
    logic [12:0] aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    int b_dly;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    aw_fire = 0; w_fire = 0; b_fire = 0; aw_got = 0; w_got = 0; b_pend = 0;
    aw_a = '0; w_d = '0; w_s = '0; b_dly = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        aw_fire = 0; w_fire = 0; b_fire = 0; aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (b_fire) begin
          m_axi_bvalid = 1'b0;
          n_bresp++;
        end
        if (aw_got && w_got) begin
          n_writes++;
          checkOutput("rel_awaddr", 32'(aw_a), 32'h17FC);
          checkOutput("rel_wdata", w_d, 32'h0);
          checkOutput("rel_wstrb", 32'(w_s), 32'hF);
          if (aw_a == 13'h17FC && !w_d[0]) frame_ready = 0;
          aw_got = 0; w_got = 0;
          b_pend = 1; b_dly = $urandom_range(0, 4);
        end
        m_axi_awready = m_axi_awvalid && !aw_got && ($urandom_range(0, 2) == 0);
        m_axi_wready  = m_axi_wvalid && !w_got && ($urandom_range(0, 2) == 0);
        aw_fire = m_axi_awready && m_axi_awvalid;
        w_fire  = m_axi_wready && m_axi_wvalid;
        if (aw_fire) aw_a = m_axi_awaddr;
        if (w_fire) begin
          w_d = m_axi_wdata;
          w_s = m_axi_wstrb;
        end
        if (b_pend) begin
          if (b_dly == 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = 2'($urandom_range(0, 3));
            b_pend = 0;
          end else begin
            b_dly--;
          end
        end
        b_fire = m_axi_bvalid && m_axi_bready;
      end
    end
  end

  initial begin : stream_sink
    bit pend, prev_stall;
    logic [31:0] prev_d;
    logic prev_l;
    int stall_left, reads_at_stall;
    m_axis_tready = 1'b0;
    pend = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0; stall_left = 0; reads_at_stall = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pend = 0; prev_stall = 0; stall_left = 0;
        m_axis_tready = 1'b0;
      end else begin
        if (pend) begin
          void'(exp_q.pop_front());
          words_seen++;
          pend = 0;
        end
        if (m_axis_tvalid) begin
          tvalid_seen = 1;
          checkOutput("no_ar_during_tvalid", 32'(m_axi_arvalid), 32'd0);
          if (prev_stall) begin
            checkOutput("tdata_stable", m_axis_tdata, prev_d);
            checkOutput("tlast_stable", 32'(m_axis_tlast), 32'(prev_l));
          end
          if (stall_armed && words_seen == stall_at) begin
            stall_armed = 0;
            stall_left = stall_len;
            reads_at_stall = n_status_reads + n_buf_reads;
          end
          if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
            if (stall_left == 0) begin
              stall_done = 1;
              checkOutput("stall_no_reads", 32'(n_status_reads + n_buf_reads), 32'(reads_at_stall));
              checkOutput("stall_not_released", 32'(frame_ready), 32'd1);
            end
          end else begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
          end
          if (m_axis_tready) begin
            checkOutput("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              checkOutput("tdata", m_axis_tdata, exp_q[0][31:0]);
              checkOutput("tlast", 32'(m_axis_tlast), 32'(exp_q[0][32]));
              pend = 1;
            end
          end
          prev_stall = !m_axis_tready;
          prev_d = m_axis_tdata;
          prev_l = m_axis_tlast;
        end else begin
          m_axis_tready = ($urandom_range(0, 1) == 1);
          prev_stall = 0;
        end
      end
    end
  end

  // Frame-level model: what the buffer holds and which words must come out.
  task automatic pushExpected(input logic [15:0] et, input int n);
    int words;
    cur_accept = (et == ETYPE) && (n != 0);
    words = (n > MAXW) ? MAXW : n;
    if (!cur_accept) words = 0;
    for (int i = 0; i < words; i++) exp_q.push_back({1'(i == words - 1), mem[4 + i]});
    cur_reads = 1 + words;
  endtask

  task automatic loadFrame(input logic [15:0] et, input int n);
    logic [7:0] hdr [16];
    for (int k = 0; k < 12; k++) hdr[k] = 8'($urandom);
    hdr[12] = et[15:8];
    hdr[13] = et[7:0];
    hdr[14] = 8'(n >> 8);
    hdr[15] = 8'(n);
    for (int k = 0; k < 16; k++) mem[k / 4][8 * (k % 4) +: 8] = hdr[k];
    for (int i = 0; i < n && i < 500; i++) mem[4 + i] = $urandom;
    pushExpected(et, n);
  endtask

  task automatic setBase();
    b_base = n_bresp;
    r_base = n_buf_reads;
    w_base = n_writes;
    words_seen = 0;
  endtask

  task automatic waitRelease(input string tag);
    int cyc;
    cyc = 0;
    while (n_bresp == b_base && cyc < 20000) begin
      @(negedge aclk);
      cyc++;
    end
    if (cur_accept) exp_ok++;
    else exp_drop++;
    checkOutput({tag, "_released"}, 32'(n_bresp - b_base), 32'd1);
    checkOutput({tag, "_frames_ok"}, 32'(frames_ok), 32'(exp_ok & 16'hFFFF));
    checkOutput({tag, "_frames_dropped"}, 32'(frames_dropped), 32'(exp_drop & 16'hFFFF));
    checkOutput({tag, "_all_words_out"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_buf_reads"}, 32'(n_buf_reads - r_base), 32'(cur_reads));
    checkOutput({tag, "_one_write"}, 32'(n_writes - w_base), 32'd1);
    checkOutput({tag, "_ready_cleared"}, 32'(frame_ready), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] et, input int n);
    loadFrame(et, n);
    setBase();
    frame_ready = 1;
    waitRelease(tag);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
    checkOutput({pfx, "_araddr"}, 32'(m_axi_araddr), 32'd0);
    checkOutput({pfx, "_rready"}, 32'(m_axi_rready), 32'd0);
    checkOutput({pfx, "_awvalid"}, 32'(m_axi_awvalid), 32'd0);
    checkOutput({pfx, "_awaddr"}, 32'(m_axi_awaddr), 32'd0);
    checkOutput({pfx, "_wvalid"}, 32'(m_axi_wvalid), 32'd0);
    checkOutput({pfx, "_wdata"}, m_axi_wdata, 32'd0);
    checkOutput({pfx, "_bready"}, 32'(m_axi_bready), 32'd0);
    checkOutput({pfx, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    checkOutput({pfx, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    checkOutput({pfx, "_tdata"}, m_axis_tdata, 32'd0);
    checkOutput({pfx, "_frames_ok"}, 32'(frames_ok), 32'd0);
    checkOutput({pfx, "_frames_dropped"}, 32'(frames_dropped), 32'd0);
  endtask

  initial begin : main
    int s0, r0, w0, cyc, status_at_reset;
    logic [15:0] et;
    int n;
    aresetn = 1'b1;
    frame_ready = 0;
    stall_armed = 0; stall_done = 0; stall_at = -1; stall_len = 0;
    tvalid_seen = 0; words_seen = 0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    #3 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checkResetOutputs("por");
    #2 aresetn = 1'b1;

    // No frame pending: only status polls, nothing else.
    s0 = n_status_reads; r0 = n_buf_reads; w0 = n_writes; tvalid_seen = 0;
    repeat (150) @(negedge aclk);
    checkOutput("idle_polls_min", 32'((n_status_reads - s0) >= 4), 32'd1);
    checkOutput("idle_polls_max", 32'((n_status_reads - s0) <= 16), 32'd1);
    checkOutput("idle_buf_reads", 32'(n_buf_reads - r0), 32'd0);
    checkOutput("idle_writes", 32'(n_writes - w0), 32'd0);
    checkOutput("idle_tvalid", 32'(tvalid_seen), 32'd0);

    applyStimulus("ok_n3", ETYPE, 3);
    applyStimulus("ipv4_drop", 16'h0800, 3);
    applyStimulus("n0_drop", ETYPE, 0);
    applyStimulus("n100_clamp", ETYPE, 100);

    stall_at = 1; stall_len = 50; stall_done = 0; stall_armed = 1;
    applyStimulus("stall", ETYPE, 5);
    checkOutput("stall_exercised", 32'(stall_done), 32'd1);

    for (int f = 0; f < 6; f++) begin
      et = ($urandom_range(0, 2) != 0) ? ETYPE : 16'($urandom);
      n = $urandom_range(0, 80);
      applyStimulus("rand", et, n);
    end

    // Reset while a word is presented; the frame must be re-read from scratch.
    loadFrame(ETYPE, 6);
    setBase();
    frame_ready = 1;
    cyc = 0;
    while (!(words_seen >= 2 && m_axis_tvalid) && cyc < 5000) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("reset_in_pay_out", 32'(m_axis_tvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1 checkResetOutputs("midrst");
    exp_q.delete();
    exp_ok = 0; exp_drop = 0;
    status_at_reset = n_status_reads;
    repeat (3) @(negedge aclk);
    pushExpected(ETYPE, 6);
    setBase();
    checkOutput("midrst_frame_pending", 32'(frame_ready), 32'd1);
    #2 aresetn = 1'b1;
    waitRelease("after_reset");
    checkOutput("after_reset_polled", 32'(n_status_reads > status_at_reset), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
